// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe referee: cell codes, FSM states and the line table.
// Cell c1 sits in board bits [1:0], c9 in bits [17:16].
package gato_pkg;

  localparam logic [1:0] CASILLA_VACIA = 2'b00;
  localparam logic [1:0] CASILLA_X     = 2'b11;
  localparam logic [1:0] CASILLA_O     = 2'b01;

  typedef enum logic [2:0] {
    ESPERA_P1,
    ESPERA_P2,
    EVALUA_P1,
    EVALUA_P2,
    FIN
  } estado_t;

  localparam logic [2:0] LINEA_F1 = 3'd0;
  localparam logic [2:0] LINEA_F2 = 3'd1;
  localparam logic [2:0] LINEA_F3 = 3'd2;
  localparam logic [2:0] LINEA_C1 = 3'd3;
  localparam logic [2:0] LINEA_C2 = 3'd4;
  localparam logic [2:0] LINEA_C3 = 3'd5;
  localparam logic [2:0] LINEA_D1 = 3'd6;
  localparam logic [2:0] LINEA_D2 = 3'd7;

  // Zero-based cell indices (c1 = 0) of each line, ordered by line index.
  localparam logic [3:0] LINEAS [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] celda(input logic [17:0] tablero, input logic [3:0] idx);
    return tablero[2*idx +: 2];
  endfunction

endpackage

// File: rtl/detector_linea.sv
// Combinational line finder: flags whether a player owns any full line and reports the lowest index.
// Zero latency, no handshake.
module detector_linea
  import gato_pkg::*;
(
  input  logic [17:0] tablero,
  input  logic [1:0]  jugador,
  output logic        hay_linea,
  output logic [2:0]  linea
);

  always_comb begin
    hay_linea = 1'b0;
    linea     = LINEA_F1;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int l = 7; l >= 0; l--) begin
      if (celda(tablero, LINEAS[l][0]) == jugador &&
          celda(tablero, LINEAS[l][1]) == jugador &&
          celda(tablero, LINEAS[l][2]) == jugador) begin
        hay_linea = 1'b1;
        linea     = 3'(l);
      end
    end
  end

endmodule

// File: rtl/arbitro_gato.sv
// Tic-tac-toe referee: synchronises move levels, validates each move, tracks turn and result.
// Move edge to outputs is SYNC_STAGES+2 cycles; no backpressure, moves outside a waiting state are dropped.
module arbitro_gato
  import gato_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reinicio_partida,
  input  logic       p1_mm,
  input  logic       p2_mm,
  input  logic [1:0] guarda_c1,
  input  logic [1:0] guarda_c2,
  input  logic [1:0] guarda_c3,
  input  logic [1:0] guarda_c4,
  input  logic [1:0] guarda_c5,
  input  logic [1:0] guarda_c6,
  input  logic [1:0] guarda_c7,
  input  logic [1:0] guarda_c8,
  input  logic [1:0] guarda_c9,
  output logic       turno_p1,
  output logic       turno_p2,
  output logic       gana_p1,
  output logic       gana_p2,
  output logic       empate,
  output logic       fin_partida,
  output logic [2:0] linea_ganadora,
  output logic [3:0] jugadas,
  output logic       error_turno,
  output logic       error_casilla
);

  logic                   limpia;
  logic [SYNC_STAGES-1:0] p1_sync_q, p2_sync_q;
  logic                   p1_prev_q, p2_prev_q;
  logic                   p1_ev, p2_ev;
  logic [17:0]            celdas_q, tablero_q;
  estado_t                estado_q;
  logic                   turno_p1_q, turno_p2_q, gana_p1_q, gana_p2_q, empate_q, fin_q;
  logic [2:0]             linea_q;
  logic [3:0]             jugadas_q;
  logic                   error_turno_q, error_casilla_q;
  logic                   es_p1, nueva, hay_linea;
  logic [1:0]             mover;
  logic [3:0]             ocupadas;
  logic [2:0]             linea;

  assign limpia = reset | reinicio_partida;
  assign p1_ev  = p1_sync_q[SYNC_STAGES-1] & ~p1_prev_q;
  assign p2_ev  = p2_sync_q[SYNC_STAGES-1] & ~p2_prev_q;

  always_ff @(posedge clk) begin
    if (limpia) begin
      p1_sync_q <= '0;
      p2_sync_q <= '0;
      p1_prev_q <= 1'b0;
      p2_prev_q <= 1'b0;
      celdas_q  <= '0;
    end else begin
      p1_sync_q <= {p1_sync_q[SYNC_STAGES-2:0], p1_mm};
      p2_sync_q <= {p2_sync_q[SYNC_STAGES-2:0], p2_mm};
      p1_prev_q <= p1_sync_q[SYNC_STAGES-1];
      p2_prev_q <= p2_sync_q[SYNC_STAGES-1];
      celdas_q  <= {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                    guarda_c4, guarda_c3, guarda_c2, guarda_c1};
    end
  end

  assign es_p1 = (estado_q == EVALUA_P1);
  assign mover = es_p1 ? CASILLA_X : CASILLA_O;

  // A legal move adds exactly one cell, and that cell must carry the mover's code.
  always_comb begin
    ocupadas = 4'd0;
    nueva    = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (celda(celdas_q, 4'(i)) != CASILLA_VACIA) ocupadas = ocupadas + 4'd1;
      if (celda(celdas_q, 4'(i)) == mover && celda(tablero_q, 4'(i)) == CASILLA_VACIA) nueva = 1'b1;
    end
  end

  detector_linea u_detector (
    .tablero   (celdas_q),
    .jugador   (mover),
    .hay_linea (hay_linea),
    .linea     (linea)
  );

  always_ff @(posedge clk) begin
    if (limpia) begin
      estado_q        <= ESPERA_P1;
      tablero_q       <= '0;
      turno_p1_q      <= 1'b1;
      turno_p2_q      <= 1'b0;
      gana_p1_q       <= 1'b0;
      gana_p2_q       <= 1'b0;
      empate_q        <= 1'b0;
      fin_q           <= 1'b0;
      linea_q         <= LINEA_F1;
      jugadas_q       <= 4'd0;
      error_turno_q   <= 1'b0;
      error_casilla_q <= 1'b0;
    end else begin
      error_turno_q   <= 1'b0;
      error_casilla_q <= 1'b0;
      case (estado_q)
        ESPERA_P1: begin
          if (p2_ev)      error_turno_q <= 1'b1;
          else if (p1_ev) estado_q      <= EVALUA_P1;
        end
        ESPERA_P2: begin
          if (p1_ev)      error_turno_q <= 1'b1;
          else if (p2_ev) estado_q      <= EVALUA_P2;
        end
        EVALUA_P1, EVALUA_P2: begin
          if (ocupadas != jugadas_q + 4'd1 || !nueva) begin
            error_casilla_q <= 1'b1;
            estado_q        <= es_p1 ? ESPERA_P1 : ESPERA_P2;
          end else begin
            tablero_q <= celdas_q;
            if (jugadas_q != 4'd9) jugadas_q <= jugadas_q + 4'd1;
            if (hay_linea) begin
              gana_p1_q  <= es_p1;
              gana_p2_q  <= !es_p1;
              linea_q    <= linea;
              fin_q      <= 1'b1;
              turno_p1_q <= 1'b0;
              turno_p2_q <= 1'b0;
              estado_q   <= FIN;
            end else if (ocupadas == 4'd9) begin
              empate_q   <= 1'b1;
              fin_q      <= 1'b1;
              turno_p1_q <= 1'b0;
              turno_p2_q <= 1'b0;
              estado_q   <= FIN;
            end else begin
              turno_p1_q <= !es_p1;
              turno_p2_q <= es_p1;
              estado_q   <= es_p1 ? ESPERA_P2 : ESPERA_P1;
            end
          end
        end
        FIN:     estado_q <= FIN;
        default: estado_q <= ESPERA_P1;
      endcase
    end
  end

  assign turno_p1       = turno_p1_q;
  assign turno_p2       = turno_p2_q;
  assign gana_p1        = gana_p1_q;
  assign gana_p2        = gana_p2_q;
  assign empate         = empate_q;
  assign fin_partida    = fin_q;
  assign linea_ganadora = linea_q;
  assign jugadas        = jugadas_q;
  assign error_turno    = error_turno_q;
  assign error_casilla  = error_casilla_q;

endmodule

// File: tb/tb_arbitro_gato.sv
// Scoreboard bench for arbitro_gato: stimulus queues expected output snapshots with a due cycle,
// a negedge monitor pops one whenever the referee reports something (reset, error pulse, move count change).
module tb_arbitro_gato;

  typedef struct packed {
    logic       tp1;
    logic       tp2;
    logic       g1;
    logic       g2;
    logic       emp;
    logic       fin;
    logic [2:0] lin;
    logic [3:0] jug;
    logic       et;
    logic       ec;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reinicio_partida = 1'b0;
  logic       p1_mm = 1'b0;
  logic       p2_mm = 1'b0;
  logic [1:0] cel [1:9];
  logic       turno_p1, turno_p2, gana_p1, gana_p2, empate, fin_partida;
  logic [2:0] linea_ganadora;
  logic [3:0] jugadas;
  logic       error_turno, error_casilla;

  localparam logic [1:0] X = 2'b11;
  localparam logic [1:0] O = 2'b01;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  logic  rst_prev = 1'b0;
  logic [3:0] prev_jug;
  snap_t exp_q[$];
  int    due_q[$];
  string name_q[$];
  snap_t act, e;
  int    d;
  string n;

  arbitro_gato #(.SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .reinicio_partida (reinicio_partida),
    .p1_mm            (p1_mm),
    .p2_mm            (p2_mm),
    .guarda_c1        (cel[1]),
    .guarda_c2        (cel[2]),
    .guarda_c3        (cel[3]),
    .guarda_c4        (cel[4]),
    .guarda_c5        (cel[5]),
    .guarda_c6        (cel[6]),
    .guarda_c7        (cel[7]),
    .guarda_c8        (cel[8]),
    .guarda_c9        (cel[9]),
    .turno_p1         (turno_p1),
    .turno_p2         (turno_p2),
    .gana_p1          (gana_p1),
    .gana_p2          (gana_p2),
    .empate           (empate),
    .fin_partida      (fin_partida),
    .linea_ganadora   (linea_ganadora),
    .jugadas          (jugadas),
    .error_turno      (error_turno),
    .error_casilla    (error_casilla)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= reset | reinicio_partida;
  end

  always @(negedge clk) begin
    act = {turno_p1, turno_p2, gana_p1, gana_p2, empate, fin_partida,
           linea_ganadora, jugadas, error_turno, error_casilla};
    if (rst_prev || error_turno || error_casilla || (jugadas !== prev_jug)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got=%h", cyc, act);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        n = name_q.pop_front();
        if (act !== e || cyc != d)
          begin
            errors++;
            $display("FAIL %s got=%h at cyc %0d want=%h at cyc %0d", n, act, cyc, e, d);
          end
      end
    end
    prev_jug = jugadas;
  end

  function automatic snap_t mk(input bit tp1, input bit tp2, input bit g1, input bit g2,
                               input bit emp, input bit fin, input int lin, input int jug,
                               input bit et, input bit ec);
    mk = {tp1, tp2, g1, g2, emp, fin, 3'(lin), 4'(jug), et, ec};
  endfunction

  function automatic snap_t rst_snap();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic expect_at(input string nm, input snap_t s, input int lat);
    exp_q.push_back(s);
    due_q.push_back(cyc + lat);
    name_q.push_back(nm);
  endtask

  // Entered and left just after a rising edge; cells are cleared for the new game.
  task automatic do_reset(input bit via_reinicio, input string nm);
    if (via_reinicio) reinicio_partida = 1'b1;
    else              reset = 1'b1;
    expect_at(nm, rst_snap(), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    reinicio_partida = 1'b0;
    for (int i = 1; i <= 9; i++) cel[i] = 2'b00;
    repeat (2) @(posedge clk); #1;
  endtask

  // c = 0 leaves the board untouched; chk = 0 expects the referee to stay silent.
  task automatic jugada(input bit jug2, input int c, input logic [1:0] code, input bit chk,
                        input string nm, input snap_t s, input int lat);
    if (c != 0) cel[c] = code;
    if (jug2) p2_mm = 1'b1;
    else      p1_mm = 1'b1;
    if (chk) expect_at(nm, s, lat);
    repeat (6) @(posedge clk); #1;
    p1_mm = 1'b0;
    p2_mm = 1'b0;
    repeat (3) @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 1; i <= 9; i++) cel[i] = 2'b00;
    do_reset(0, "reset_inicial");

    // Game 1: p1 wins the top row.
    jugada(0, 1, X, 1, "g1_p1_c1", mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 4);
    jugada(1, 4, O, 1, "g1_p2_c4", mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 0), 4);
    jugada(0, 2, X, 1, "g1_p1_c2", mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0), 4);
    jugada(1, 5, O, 1, "g1_p2_c5", mk(1, 0, 0, 0, 0, 0, 0, 4, 0, 0), 4);
    jugada(0, 3, X, 1, "g1_gana_p1", mk(0, 0, 1, 0, 0, 1, 0, 5, 0, 0), 4);
    jugada(1, 6, O, 0, "", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    jugada(0, 0, X, 0, "", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    do_reset(1, "reinicio_en_fin");

    // Game 2: p2 wins the c3-c5-c7 diagonal.
    jugada(0, 1, X, 1, "g2_p1_c1", mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 4);
    jugada(1, 3, O, 1, "g2_p2_c3", mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 0), 4);
    jugada(0, 2, X, 1, "g2_p1_c2", mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0), 4);
    jugada(1, 5, O, 1, "g2_p2_c5", mk(1, 0, 0, 0, 0, 0, 0, 4, 0, 0), 4);
    jugada(0, 4, X, 1, "g2_p1_c4", mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 0), 4);
    jugada(1, 7, O, 1, "g2_gana_p2", mk(0, 0, 0, 1, 0, 1, 7, 6, 0, 0), 4);
    do_reset(0, "reset_en_fin");

    // Game 3: wrong-turn and occupied-cell errors, then a draw.
    jugada(1, 0, O, 1, "error_turno", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 3);
    jugada(0, 1, X, 1, "g3_p1_c1", mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 4);
    jugada(1, 3, O, 1, "g3_p2_c3", mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 0), 4);
    jugada(0, 2, X, 1, "g3_p1_c2", mk(0, 1, 0, 0, 0, 0, 0, 3, 0, 0), 4);
    jugada(1, 4, O, 1, "g3_p2_c4", mk(1, 0, 0, 0, 0, 0, 0, 4, 0, 0), 4);
    jugada(0, 6, X, 1, "g3_p1_c6", mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 0), 4);
    jugada(1, 1, O, 1, "error_casilla", mk(0, 1, 0, 0, 0, 0, 0, 5, 0, 1), 4);
    cel[1] = X;
    repeat (2) @(posedge clk); #1;
    jugada(1, 5, O, 1, "g3_p2_c5", mk(1, 0, 0, 0, 0, 0, 0, 6, 0, 0), 4);
    jugada(0, 7, X, 1, "g3_p1_c7", mk(0, 1, 0, 0, 0, 0, 0, 7, 0, 0), 4);
    jugada(1, 8, O, 1, "g3_p2_c8", mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 0), 4);
    jugada(0, 9, X, 1, "g3_empate", mk(0, 0, 0, 0, 1, 1, 0, 9, 0, 0), 4);
    do_reset(0, "reset_tras_empate");

    // New game mid-play, then a new game landing on the same cycle as a move edge.
    jugada(0, 5, X, 1, "g4_p1_c5", mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 4);
    do_reset(1, "reinicio_a_mitad");
    cel[5] = X;
    p1_mm = 1'b1;
    repeat (2) @(posedge clk); #1;
    p1_mm = 1'b0;
    do_reset(1, "reinicio_con_flanco");
    repeat (8) @(posedge clk); #1;
    jugada(0, 9, X, 1, "g5_p1_c9", mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 4);
    jugada(0, 0, X, 1, "error_turno_p1", mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0), 3);

    repeat (10) @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pendientes got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
